// File: rtl/seq_div_24_12.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional ovf output (quotient exceeds N bits) is enabled by defining SEQ_DIV_OVF_EN.
module seq_div_24_12 #(
  parameter int unsigned N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
`ifdef SEQ_DIV_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    q;
  logic [N-1:0]    dvs;
  logic [N-1:0]    r;
  logic [CW-1:0]   cnt;
  logic            dbz_r;

  logic            load;
  logic            zero_div;
  logic            fits;
  logic [N:0]      shifted;
  logic [N-1:0]    r_next;
  logic            busy_next;
  logic            done_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, control strobes and one restoring step on the current partial remainder.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    zero_div   = 1'b0;
    shifted    = {r, q[W-1]};
    fits       = shifted >= {1'b0, dvs};
    r_next     = fits ? N'(shifted - {1'b0, dvs}) : shifted[N-1:0];
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        // A zero divisor is caught on the captured operand in the first CALC cycle.
        if (cnt == '0 && dvs == '0) begin
          zero_div   = 1'b1;
          state_next = DONE;
        end else if (cnt == CW'(W - 1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE) || (state == DONE);
    done_next = (state == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      dvs       <= '0;
      r         <= '0;
      cnt       <= '0;
      dbz_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
`ifdef SEQ_DIV_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (load) begin
        q     <= dividend;
        dvs   <= divisor;
        r     <= '0;
        cnt   <= '0;
        dbz_r <= 1'b0;
      end else if (state == CALC) begin
        if (zero_div) begin
          q     <= '1;
          r     <= q[N-1:0];
          dbz_r <= 1'b1;
        end else begin
          q   <= {q[W-2:0], fits};
          r   <= r_next;
          cnt <= cnt + CW'(1);
        end
      end
      if (state == DONE) begin
        quotient  <= q;
        remainder <= r;
        dbz       <= dbz_r;
`ifdef SEQ_DIV_OVF_EN
        ovf       <= !dbz_r && (q[W-1:N] != '0);
`endif
      end
    end
  end

endmodule
